scope_frame_reader: RTL and testbench
=====================================

# scope_frame_reader

Read side of the sample RAM. After the capture path signals a complete frame, the block reads the frame out of the RAM: 200 points in single-channel mode, 400 points in dual-channel mode. It presents each sample to the display path over a valid/ready stream, tagged with its X position and channel. Sequencing is the inverse of the capture address counter; the block tolerates one-cycle RAM read latency and back-pressure.

## Interface
- DATA_WIDTH, 8, sample width of RAM data and output
- SINGLE_POINTS, 200, frame length when sample_type=0
- DUAL_POINTS, 400, frame length when sample_type=1 (must be even, ≤512)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- frame_ready  in  1  one-cycle pulse: capture finished a frame
- sample_type  in  1  1 = dual channel (400 pts), 0 = single (200 pts); sampled on frame start
- ram_rd_en  out  1  read strobe to sample RAM
- ram_rd_addr  out  9  read address
- ram_rd_data  in  DATA_WIDTH  RAM data, valid exactly 1 cycle after ram_rd_en
- out_valid  out  1  output sample valid
- out_ready  in  1  display path accepts when out_valid && out_ready
- out_data  out  DATA_WIDTH  sample value
- out_x  out  8  horizontal position 0..199
- out_channel  out  1  0 = CH1, 1 = CH2
- out_last  out  1  high on final sample of frame
- busy  out  1  high from frame start until last sample accepted
- frame_done  out  1  one-cycle pulse on acceptance of last sample
- frame_drop  out  1  one-cycle pulse when frame_ready arrives while busy

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: on frame_ready, latch mode from sample_type, set length N (SINGLE_POINTS or DUAL_POINTS), clear read address to 0, go READ, assert busy.
- READ: issue reads at addresses 0..N-1 in order.
  - A read issues when (entries in output buffer + reads in flight) < 2.
  - After issuing address N-1, go DRAIN.
- DRAIN: no reads. Leave for IDLE when the last sample is accepted; pulse frame_done on that same cycle.
- Output buffer: 2-entry FIFO capturing ram_rd_data one cycle after each ram_rd_en. It never overflows.
- Tagging, for address a:
  - Single mode: out_x = a, out_channel = 0.
  - Dual mode: out_channel = a[0], out_x = a>>1. Samples are interleaved: even address is CH1, odd address is CH2.
  - out_last = 1 for a = N-1.
- Tags travel with the data through the FIFO.
- sample_type changes while busy have no effect on the current frame.
- frame_ready while busy is ignored: pulse frame_drop, current frame continues. Not queued.
- frame_ready on the same cycle as the frame_done acceptance is also dropped.
- ram_rd_addr holds its last value when ram_rd_en = 0.

## Timing
- Reset values, applied on the next edge with reset = 1 from any state:
  - State IDLE, FIFO and in-flight counter cleared.
  - ram_rd_en=0, ram_rd_addr=0, out_valid=0, out_data=0, out_x=0, out_channel=0, out_last=0.
  - busy=0, frame_done=0, frame_drop=0.
  - A read in flight during reset is discarded.
- Start latency:
  - frame_ready sampled at edge T: busy=1 and first ram_rd_en=1 (addr 0) after T.
  - out_valid first high after T+2.
- With out_ready held 1: one sample per cycle, no bubbles. Frame of N samples occupies N+2 cycles from start to frame_done.
- Back-pressure:
  - out_valid stays asserted and out_data/out_x/out_channel/out_last are stable until accepted.
  - Reads stall within one cycle of the FIFO filling.
- frame_done and frame_drop are registered single-cycle pulses.
- busy deasserts the cycle after frame_done. A new frame_ready is accepted from that cycle on.

## Test plan
- Single mode, out_ready=1, RAM preloaded data=addr[7:0]:
  - Expect 200 samples, out_x 0..199, data 0..199, out_channel=0.
  - out_last only on x=199; frame_done exactly 202 cycles after frame_ready.
- Dual mode, out_ready=1:
  - Expect 400 samples alternating CH1/CH2, out_x 0,0,1,1,…,199,199, data = address.
  - Last sample has out_channel=1, x=199.
- Random out_ready (50%), dual mode:
  - No lost, duplicated or reordered samples.
  - Outputs stable while stalled; ram_rd_en never issued with 2 entries pending.
- frame_ready pulsed mid-frame and on the frame_done cycle:
  - frame_drop pulses both times; current frame completes unaltered; no second frame starts.
- Toggle sample_type mid-frame after a single-mode start: still exactly 200 samples.
- Assert reset at sample 57 with out_valid=1 and a read in flight:
  - All outputs return to reset values next cycle.
  - A following frame_ready starts cleanly from address 0.

Source files
------------

// File: rtl/scope_frame_reader.sv
// Purpose  : reads one captured scope frame out of the sample RAM and streams it to the display path,
//            tagging each sample with its X position and channel.
// Latency  : first read strobe the cycle after frame_ready is sampled; first sample valid two cycles later.
// Backpres.: 2-entry output FIFO; reads are only issued while buffered plus in-flight samples leave room.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   frame_ready, sample_type frame-complete pulse from capture; channel mode latched at frame start
//   ram_rd_en/addr/data      sample RAM read port, data returns one cycle after the strobe
//   out_valid/ready          display stream handshake; out_data/x/channel/last ride with each sample
//   busy, frame_done         frame in progress; pulse after the last sample is accepted
//   frame_drop               pulse when a frame_ready is ignored because a frame is still in progress

// Two-entry FIFO used as the output skid buffer. Storage is cleared on reset so the
// head reads zero afterwards.
module sfr_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic             head_vld,
   output logic [WIDTH-1:0] head_dat,
   output logic [1:0]       count
);
   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             pop_en;

   assign pop_en   = pop_rdy && head_vld;
   assign head_vld = (count_q != 2'd0);
   assign head_dat = mem_q[rd_ptr_q];
   assign count    = count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_vld) begin
            mem_q[wr_ptr_q] <= push_dat;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_en) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push_vld} - {1'b0, pop_en};
      end
   end
endmodule

module scope_frame_reader #(
   parameter int DATA_WIDTH    = 8,
   parameter int SINGLE_POINTS = 200,
   parameter int DUAL_POINTS   = 400
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  frame_ready,
   input  logic                  sample_type,
   output logic                  ram_rd_en,
   output logic [8:0]            ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [7:0]            out_x,
   output logic                  out_channel,
   output logic                  out_last,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  frame_drop
);
   localparam int TAG_W = DATA_WIDTH + 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       mode_q;          // 1 = dual channel, latched at frame start
   logic [8:0] len_m1_q;        // address of the final sample of the frame
   logic [8:0] next_addr_q;     // address the next read will use
   logic [8:0] last_addr_q;     // address of the most recent read, shown while idle
   logic       pend_vld_q;      // read issued last cycle, data is on ram_rd_data now
   logic [7:0] pend_x_q;
   logic       pend_ch_q;
   logic       pend_last_q;
   logic       busy_q;
   logic       frame_done_q;
   logic       frame_drop_q;

   logic             start;
   logic             rd_en;
   logic             pop;
   logic             accept_last;
   logic             addr_is_last;
   logic [2:0]       occ;
   logic [1:0]       fifo_cnt;
   logic [TAG_W-1:0] head_dat;
   logic [7:0]       tag_x;
   logic             tag_ch;

   sfr_fifo2 #(.WIDTH(TAG_W)) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push_vld (pend_vld_q),
      .push_dat ({ram_rd_data, pend_x_q, pend_ch_q, pend_last_q}),
      .pop_rdy  (out_ready),
      .head_vld (out_valid),
      .head_dat (head_dat),
      .count    (fifo_cnt)
   );

   assign {out_data, out_x, out_channel, out_last} = head_dat;

   assign pop          = out_valid && out_ready;
   assign accept_last  = pop && out_last;
   assign start        = frame_ready && !busy_q;
   assign addr_is_last = (next_addr_q == len_m1_q);
   assign tag_x        = mode_q ? next_addr_q[8:1] : next_addr_q[7:0];
   assign tag_ch       = mode_q & next_addr_q[0];

   // Occupancy after this cycle's pop: buffered entries plus the read whose data is
   // on the bus. Crediting the pop keeps one sample per cycle while never letting
   // buffered + returning samples exceed the two FIFO slots.
   assign occ = {1'b0, fifo_cnt} + {2'b00, pend_vld_q} - {2'b00, pop};

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = READ;
         end
         READ: begin
            rd_en = (occ < 3'd2);
            if (rd_en && addr_is_last) state_d = DRAIN;
         end
         DRAIN: begin
            if (accept_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ram_rd_en   = rd_en;
   assign ram_rd_addr = rd_en ? next_addr_q : last_addr_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign frame_drop  = frame_drop_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         mode_q       <= 1'b0;
         len_m1_q     <= 9'(SINGLE_POINTS - 1);
         next_addr_q  <= 9'd0;
         last_addr_q  <= 9'd0;
         pend_vld_q   <= 1'b0;
         pend_x_q     <= 8'd0;
         pend_ch_q    <= 1'b0;
         pend_last_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         frame_drop_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= (state_q == DRAIN) && accept_last;
         frame_drop_q <= frame_ready && busy_q;
         // busy spans the frame_done cycle so a frame_ready there is still dropped
         if (start) begin
            busy_q <= 1'b1;
         end else if (frame_done_q) begin
            busy_q <= 1'b0;
         end
         if (start) begin
            mode_q      <= sample_type;
            len_m1_q    <= sample_type ? 9'(DUAL_POINTS - 1) : 9'(SINGLE_POINTS - 1);
            next_addr_q <= 9'd0;
         end else if (rd_en) begin
            last_addr_q <= next_addr_q;
            next_addr_q <= next_addr_q + 9'd1;
         end
         pend_vld_q <= rd_en;
         if (rd_en) begin
            pend_x_q    <= tag_x;
            pend_ch_q   <= tag_ch;
            pend_last_q <= addr_is_last;
         end
      end
   end
endmodule

// File: tb/tb_scope_frame_reader.sv
module tb_scope_frame_reader;
   logic       clock = 1'b0;
   logic       reset, frame_ready, sample_type, out_ready;
   logic       ram_rd_en;
   logic [8:0] ram_rd_addr;
   logic [7:0] ram_rd_data;
   logic       out_valid, out_channel, out_last, busy, frame_done, frame_drop;
   logic [7:0] out_data, out_x;

   always #5 clock = ~clock;

   scope_frame_reader dut (
      .clock       (clock),
      .reset       (reset),
      .frame_ready (frame_ready),
      .sample_type (sample_type),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_x       (out_x),
      .out_channel (out_channel),
      .out_last    (out_last),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_drop  (frame_drop)
   );

   // Sample RAM with one-cycle read latency
   logic [7:0] ram [512];
   always @(posedge clock) if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] x;
      logic       ch;
      logic       last;
   } smp_t;

   typedef struct {
      bit dual;
      int pct;
      bit toggle;
      bit drop_mid;
      bit drop_acc;
      bit drop_done;
      int exp_n;
      int exp_lat;
      int exp_drops;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   smp_t exp_q[$];
   bit   mb, exp_done, exp_drop, prev_stall, first_rd;
   smp_t prev_out;
   int   issued, accepted, cur_n, step_no, start_step, lat_meas, drops_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Expected frame contents straight from the tagging rules
   task automatic build_frame(input bit dual);
      smp_t s;
      cur_n = dual ? 400 : 200;
      exp_q.delete();
      for (int a = 0; a < cur_n; a++) begin
         s.d    = ram[a];
         s.x    = dual ? 8'(a / 2) : 8'(a);
         s.ch   = dual ? 1'(a % 2) : 1'b0;
         s.last = (a == cur_n - 1);
         exp_q.push_back(s);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, observe, then advance the model
   task automatic step(input logic fr, input logic st, input logic rdy);
      logic pop, nd;
      bit   mb_old;
      smp_t s;
      @(negedge clock);
      frame_ready = fr;
      sample_type = st;
      out_ready   = rdy;
      #1;
      step_no++;
      mb_old = mb;
      pop    = (out_valid === 1'b1) && rdy;
      nd     = 1'b0;
      check("busy", busy, mb);
      check("frame_done", frame_done, exp_done);
      check("frame_drop", frame_drop, exp_drop);
      if (frame_drop === 1'b1) drops_seen++;
      if (frame_done === 1'b1) lat_meas = step_no - start_step - 1;
      if (prev_stall) begin
         check("held valid", out_valid, 1);
         check("held sample", {out_data, out_x, out_channel, out_last}, prev_out);
      end
      if (first_rd) check("first read strobe", ram_rd_en, 1);
      if (ram_rd_en === 1'b1) begin
         check("read while idle", mb, 1);
         check("read address", ram_rd_addr, issued);
         check("read within frame", issued < cur_n, 1);
         check("entries+in-flight bound", (issued - accepted - int'(pop)) <= 1, 1);
         issued++;
      end
      if (pop) begin
         check("sample available", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            check("sample", {out_data, out_x, out_channel, out_last}, s);
            nd = s.last;
            accepted++;
         end
      end
      prev_stall = (out_valid === 1'b1) && !rdy;
      prev_out   = {out_data, out_x, out_channel, out_last};
      first_rd   = 1'b0;
      exp_drop   = fr && mb_old;
      if (exp_done) mb = 1'b0;
      exp_done = nd;
      if (fr && !mb_old) begin
         build_frame(st);
         issued     = 0;
         accepted   = 0;
         start_step = step_no;
         first_rd   = 1'b1;
         mb         = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset       = 1'b1;
      frame_ready = 1'b0;
      out_ready   = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst ram_rd_en", ram_rd_en, 0);
      check("rst ram_rd_addr", ram_rd_addr, 0);
      check("rst out_valid", out_valid, 0);
      check("rst out_data", out_data, 0);
      check("rst out_x", out_x, 0);
      check("rst out_channel", out_channel, 0);
      check("rst out_last", out_last, 0);
      check("rst busy", busy, 0);
      check("rst frame_done", frame_done, 0);
      check("rst frame_drop", frame_drop, 0);
      mb = 0; exp_done = 0; exp_drop = 0; prev_stall = 0; first_rd = 0;
      exp_q.delete();
      cur_n = 0; issued = 0; accepted = 0;
   endtask

   function automatic logic rnd_ready(input int pct);
      return ($urandom_range(99, 0) < pct);
   endfunction

   task automatic run_vec(input vec_t v);
      bit   mid_sent;
      logic fr, st;
      for (int a = 0; a < 512; a++) ram[a] = (v.pct == 100) ? 8'(a) : 8'($urandom);
      lat_meas   = -1;
      drops_seen = 0;
      mid_sent   = 1'b0;
      step(1'b1, v.dual, rnd_ready(v.pct));
      for (int k = 0; k < 5000 && mb; k++) begin
         fr = 1'b0;
         if (v.drop_mid && !mid_sent && accepted >= cur_n / 3) begin
            fr = 1'b1;
            mid_sent = 1'b1;
         end
         if (v.drop_acc && accepted == cur_n - 1) fr = 1'b1;
         if (v.drop_done && exp_done) fr = 1'b1;
         st = v.toggle ? 1'($urandom) : v.dual;
         // the acceptance-cycle drop needs the last sample taken that cycle
         step(fr, st, (v.drop_acc && accepted == cur_n - 1) ? 1'b1 : rnd_ready(v.pct));
      end
      check("frame completes", mb, 0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check("samples accepted", accepted, v.exp_n);
      check("drops", drops_seen, v.exp_drops);
      check("leftover samples", exp_q.size(), 0);
      if (v.exp_lat >= 0) check("done latency", lat_meas, v.exp_lat);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b0, 200, 202, 0};
      vecs[1] = '{1'b1, 100, 1'b0, 1'b0, 1'b0, 1'b0, 400, 402, 0};
      vecs[2] = '{1'b1,  50, 1'b0, 1'b0, 1'b0, 1'b0, 400,  -1, 0};
      vecs[3] = '{1'b0, 100, 1'b0, 1'b1, 1'b1, 1'b1, 200, 202, 3};
      vecs[4] = '{1'b0,  60, 1'b1, 1'b0, 1'b0, 1'b0, 200,  -1, 0};
      vecs[5] = '{1'b1,  40, 1'b1, 1'b1, 1'b0, 1'b1, 400,  -1, 2};

      reset       = 1'b1;
      frame_ready = 1'b0;
      sample_type = 1'b0;
      out_ready   = 1'b0;
      ram_rd_data = 8'd0;
      step_no     = 0;
      start_step  = 0;
      do_reset();

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Reset in the middle of a frame, with a sample waiting and a read outstanding
      for (int a = 0; a < 512; a++) ram[a] = 8'(a);
      step(1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 500 && accepted < 57; k++) step(1'b0, 1'b0, 1'b1);
      check("samples before reset", accepted, 57);
      check("valid at reset point", out_valid, 1);
      check("read in flight at reset point", ram_rd_en, 1);
      do_reset();
      step(1'b0, 1'b0, 1'b1);
      check("idle after reset", busy, 0);
      run_vec(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
